// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline hazard controller for the five-stage MIPS core. Each cycle it
//   decides whether the D-stage instruction may advance into ID/EX, or whether
//   PC and IF/ID must hold while ID/EX is flushed to a bubble. It also owns the
//   multi-cycle mult/div busy countdown and a saturating stall-cycle counter.
//
// Ports
//   clk, clr               clock, asynchronous active-high reset
//   rsD, rtD               D-stage source registers
//   use_rsD, use_rtD       D-stage instruction reads rs / rt
//   tuse_rsD, tuse_rtD     cycles until each operand is needed
//   A3E, A3M               destination register in E / M (0 = no write)
//   tnewE, tnewM           cycles until the E / M result is forwardable
//   md_useD                D-stage instruction touches the mult/div unit
//   md_startE, md_divE     E-stage mult/div start, 1 = div
//   stallF, stallD         hold PC / hold IF/ID
//   flushE                 clear ID/EX at the next edge
//   md_busy                mult/div unit is computing
//   stall_cycles           saturating count of stalled cycles
//
// Handshake: there is no valid/ready pair here. stall is the single
// back-pressure signal; while it is high the D instruction is held and a
// bubble enters E, and it is re-evaluated every cycle with zero latency.
module hazard_ctrl #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [4:0]  rsD,
    input  logic [4:0]  rtD,
    input  logic        use_rsD,
    input  logic        use_rtD,
    input  logic [1:0]  tuse_rsD,
    input  logic [1:0]  tuse_rtD,
    input  logic [4:0]  A3E,
    input  logic [4:0]  A3M,
    input  logic [1:0]  tnewE,
    input  logic [1:0]  tnewM,
    input  logic        md_useD,
    input  logic        md_startE,
    input  logic        md_divE,
    output logic        stallF,
    output logic        stallD,
    output logic        flushE,
    output logic        md_busy,
    output logic [15:0] stall_cycles
);

    localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    md_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic rs_hz, rt_hz, md_hz, stall;

    // E and M matches are independent; a producer in either stage that is
    // not ready by the time the operand is used forces a stall.
    always_comb begin
        rs_hz = use_rsD && (rsD != 5'd0) &&
                (((rsD == A3E) && (tnewE > tuse_rsD)) ||
                 ((rsD == A3M) && (tnewM > tuse_rsD)));
        rt_hz = use_rtD && (rtD != 5'd0) &&
                (((rtD == A3E) && (tnewE > tuse_rtD)) ||
                 ((rtD == A3M) && (tnewM > tuse_rtD)));
        // md_startE is included so a mult/div consumer right behind the
        // starting instruction stalls before md_busy has risen.
        md_hz = md_useD && (md_busy || md_startE);
        stall = rs_hz || rt_hz || md_hz;
    end

    assign stallF       = stall;
    assign stallD       = stall;
    assign flushE       = stall;
    assign md_busy      = (state_q == BUSY);
    assign stall_cycles = stall_cnt_q;

    // Busy countdown; a start while already busy simply reloads.
    always_comb begin
        cnt_d = cnt_q;
        if (md_startE) begin
            cnt_d = md_divE ? DIV_LD : MULT_LD;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
        state_d = (cnt_d != 4'd0) ? BUSY : IDLE;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic [4:0]  rsD, rtD, A3E, A3M;
    logic        use_rsD, use_rtD;
    logic [1:0]  tuse_rsD, tuse_rtD, tnewE, tnewM;
    logic        md_useD, md_startE, md_divE;
    logic        stallF, stallD, flushE, md_busy;
    logic [15:0] stall_cycles;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: remaining busy cycles and stall count as plain integers.
    int m_rem = 0;
    int m_sc  = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk(clk), .clr(clr),
        .rsD(rsD), .rtD(rtD), .use_rsD(use_rsD), .use_rtD(use_rtD),
        .tuse_rsD(tuse_rsD), .tuse_rtD(tuse_rtD),
        .A3E(A3E), .A3M(A3M), .tnewE(tnewE), .tnewM(tnewM),
        .md_useD(md_useD), .md_startE(md_startE), .md_divE(md_divE),
        .stallF(stallF), .stallD(stallD), .flushE(flushE),
        .md_busy(md_busy), .stall_cycles(stall_cycles)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A source operand is late if some producer writing it is not ready in time.
    function automatic bit operand_late(input int r, input bit used, input int tuse);
        bit late_e, late_m;
        if (!used || r == 0) return 1'b0;
        late_e = (r == int'(A3E)) && (int'(tnewE) > tuse);
        late_m = (r == int'(A3M)) && (int'(tnewM) > tuse);
        return late_e || late_m;
    endfunction

    function automatic bit model_stall();
        bit md_conflict;
        md_conflict = md_useD && ((m_rem > 0) || md_startE);
        return operand_late(int'(rsD), use_rsD, int'(tuse_rsD)) ||
               operand_late(int'(rtD), use_rtD, int'(tuse_rtD)) || md_conflict;
    endfunction

    task automatic apply_clr();
        if (clr) begin
            m_rem = 0;
            m_sc  = 0;
        end
    endtask

    task automatic check_all(input string tag);
        bit s;
        apply_clr();
        s = model_stall();
        check({tag, ".stallF"}, 32'(stallF), 32'(s));
        check({tag, ".stallD"}, 32'(stallD), 32'(s));
        check({tag, ".flushE"}, 32'(flushE), 32'(s));
        check({tag, ".md_busy"}, 32'(md_busy), 32'(m_rem > 0));
        check({tag, ".stall_cycles"}, 32'(stall_cycles), 32'(m_sc));
    endtask

    // Advance one clock; model consumes the inputs held across the edge.
    task automatic tick();
        bit s;
        apply_clr();
        s = model_stall();
        @(posedge clk);
        if (clr) begin
            m_rem = 0;
            m_sc  = 0;
        end else begin
            if (md_startE)       m_rem = md_divE ? 10 : 5;
            else if (m_rem > 0)  m_rem = m_rem - 1;
            if (s && m_sc < 65535) m_sc = m_sc + 1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        rsD = 5'd0; rtD = 5'd0; use_rsD = 1'b0; use_rtD = 1'b0;
        tuse_rsD = 2'd0; tuse_rtD = 2'd0;
        A3E = 5'd0; A3M = 5'd0; tnewE = 2'd0; tnewM = 2'd0;
        md_useD = 1'b0; md_startE = 1'b0; md_divE = 1'b0;
    endtask

    initial begin
        int busy_n;
        idle_inputs();
        clr = 1'b1;
        #2;
        check_all("reset");
        check("reset.busy_const", 32'(md_busy), 32'd0);
        tick();
        clr = 1'b0;
        tick();

        // Load-use on rs from E, then resolved once the producer is in M.
        rsD = 5'd5; use_rsD = 1'b1; tuse_rsD = 2'd1; A3E = 5'd5; tnewE = 2'd2;
        #3;
        check_all("loaduse");
        check("loaduse.stall_const", 32'(stallF), 32'd1);
        tick();
        A3E = 5'd0; tnewE = 2'd0; A3M = 5'd5; tnewM = 2'd1;
        #3;
        check_all("loaduse_m");
        check("loaduse_m.stall_const", 32'(flushE), 32'd0);
        tick();

        // $0 never hazards; unused rt never hazards.
        idle_inputs();
        rsD = 5'd0; A3E = 5'd0; tnewE = 2'd2; use_rsD = 1'b1;
        #3;
        check_all("reg0");
        check("reg0.const", 32'(stallD), 32'd0);
        tick();
        idle_inputs();
        rtD = 5'd7; A3E = 5'd7; tnewE = 2'd2; use_rtD = 1'b0;
        #3;
        check_all("rt_unused");
        check("rt_unused.const", 32'(stallD), 32'd0);
        tick();

        // Mult: stall cycles 0..5, busy 1..5, issue in cycle 6.
        idle_inputs();
        md_useD = 1'b1; md_startE = 1'b1; md_divE = 1'b0;
        for (int c = 0; c <= 6; c++) begin
            #3;
            check_all($sformatf("mult_c%0d", c));
            check($sformatf("mult_c%0d.stall_const", c), 32'(stallF), 32'(c <= 5));
            check($sformatf("mult_c%0d.busy_const", c), 32'(md_busy), 32'(c >= 1 && c <= 5));
            tick();
            md_startE = 1'b0;
        end

        // Div with an unrelated D instruction: busy exactly 10 cycles, no stall.
        idle_inputs();
        md_startE = 1'b1; md_divE = 1'b1;
        busy_n = 0;
        for (int c = 0; c <= 12; c++) begin
            #3;
            check_all($sformatf("div_c%0d", c));
            check($sformatf("div_c%0d.nostall", c), 32'(stallD), 32'd0);
            if (md_busy) busy_n++;
            tick();
            md_startE = 1'b0;
        end
        check("div.busy_len", 32'(busy_n), 32'd10);

        // Async reset mid-div at cnt=6 (fifth cycle after the start edge).
        md_startE = 1'b1; md_divE = 1'b1; md_useD = 1'b1;
        tick();
        md_startE = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        #2;
        check_all("pre_clr");
        clr = 1'b1;
        #1;
        check_all("async_clr");
        check("async_clr.busy_const", 32'(md_busy), 32'd0);
        check("async_clr.sc_const", 32'(stall_cycles), 32'd0);
        tick();
        clr = 1'b0;
        idle_inputs();
        tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
            use_rsD = 1'($urandom_range(0, 1)); use_rtD = 1'($urandom_range(0, 1));
            tuse_rsD = 2'($urandom_range(0, 2)); tuse_rtD = 2'($urandom_range(0, 2));
            A3E = 5'($urandom_range(0, 3)); A3M = 5'($urandom_range(0, 3));
            tnewE = 2'($urandom_range(0, 3)); tnewM = 2'($urandom_range(0, 3));
            md_useD = 1'($urandom_range(0, 1));
            md_startE = ($urandom_range(0, 7) == 0);
            md_divE = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 99) == 0);
            #3;
            check_all("rand");
            tick();
        end
        clr = 1'b0;

        // Saturation under a continuous stall.
        idle_inputs();
        rsD = 5'd9; use_rsD = 1'b1; tuse_rsD = 2'd0; A3E = 5'd9; tnewE = 2'd1;
        for (int n = 0; n < 70000; n++) tick();
        #3;
        check_all("saturate");
        check("saturate.const", 32'(stall_cycles), 32'h0000FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
